// File: rtl/fwd_hazard_unit_n.sv
// Decode-stage operand forwarding, hazard detection and partial-issue control for an N-lane in-order pipeline.
// Tracks long-latency destinations in a scoreboard and last-cycle loads for one-cycle load-use stalls.
module fwd_hazard_unit_n #(
    parameter int ISSUE_W = 2,
    parameter int XLEN    = 32,
    parameter int RF_AW   = 5,
    parameter int CNT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     issue_ready,
    input  logic [ISSUE_W-1:0]       dec_valid,
    input  logic [ISSUE_W*RF_AW-1:0] dec_rs1_addr,
    input  logic [ISSUE_W*RF_AW-1:0] dec_rs2_addr,
    input  logic [ISSUE_W*RF_AW-1:0] dec_rd_addr,
    input  logic [ISSUE_W-1:0]       dec_rd_wen,
    input  logic [ISSUE_W-1:0]       dec_is_load,
    input  logic [ISSUE_W-1:0]       dec_is_long,
    input  logic [ISSUE_W*XLEN-1:0]  rf_rs1_data,
    input  logic [ISSUE_W*XLEN-1:0]  rf_rs2_data,
    input  logic [ISSUE_W*RF_AW-1:0] ex_rd_addr,
    input  logic [ISSUE_W-1:0]       ex_rd_wen,
    input  logic [ISSUE_W*XLEN-1:0]  ex_alu_data,
    input  logic [ISSUE_W*RF_AW-1:0] mem_rd_addr,
    input  logic [ISSUE_W-1:0]       mem_rd_wen,
    input  logic [ISSUE_W-1:0]       mem_is_load,
    input  logic [ISSUE_W*XLEN-1:0]  mem_alu_data,
    input  logic [ISSUE_W*XLEN-1:0]  mem_ld_data,
    input  logic [ISSUE_W*RF_AW-1:0] wb_rd_addr,
    input  logic [ISSUE_W-1:0]       wb_rd_wen,
    input  logic [ISSUE_W*XLEN-1:0]  wb_data,
    input  logic                     long_done,
    input  logic [RF_AW-1:0]         long_done_rd,
    input  logic [XLEN-1:0]          long_done_data,
    input  logic                     long_ready,
    output logic [ISSUE_W*XLEN-1:0]  rs1_data,
    output logic [ISSUE_W*XLEN-1:0]  rs2_data,
    output logic [ISSUE_W-1:0]       issue_mask,
    output logic                     stall_req,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int NREG = 2**RF_AW;

    logic [NREG-1:0]          busy_r;
    logic [NREG-1:0]          busyNext_s;
    logic [ISSUE_W-1:0]       ldValid_r;
    logic [ISSUE_W*RF_AW-1:0] ldRd_r;
    logic [ISSUE_W-1:0]       hazard_s;
    logic [ISSUE_W-1:0]       issueMask_s;
    logic [ISSUE_W-1:0]       laneGo_s;
    logic                     stallReq_s;
    logic [CNT_W-1:0]         stallCnt_r;

    // A completing long op frees its register in the same cycle it is forwarded.
    function automatic logic effBusy(input logic [RF_AW-1:0] r);
        return busy_r[r] & ~(long_done & (long_done_rd == r));
    endfunction

    function automatic logic [XLEN-1:0] fwdOperand(input logic [RF_AW-1:0] a,
                                                   input logic [XLEN-1:0]  rfData);
        logic [XLEN-1:0] v;
        logic            hit;
        logic            m;
        v   = rfData;
        hit = 1'b0;
        for (int k = ISSUE_W - 1; k >= 0; k--) begin
            m   = ~hit & ex_rd_wen[k] & (ex_rd_addr[k*RF_AW +: RF_AW] == a);
            v   = m ? ex_alu_data[k*XLEN +: XLEN] : v;
            hit = hit | m;
        end
        for (int k = ISSUE_W - 1; k >= 0; k--) begin
            m   = ~hit & mem_rd_wen[k] & (mem_rd_addr[k*RF_AW +: RF_AW] == a);
            v   = m ? (mem_is_load[k] ? mem_ld_data[k*XLEN +: XLEN]
                                      : mem_alu_data[k*XLEN +: XLEN]) : v;
            hit = hit | m;
        end
        for (int k = ISSUE_W - 1; k >= 0; k--) begin
            m   = ~hit & wb_rd_wen[k] & (wb_rd_addr[k*RF_AW +: RF_AW] == a);
            v   = m ? wb_data[k*XLEN +: XLEN] : v;
            hit = hit | m;
        end
        m = ~hit & long_done & (long_done_rd == a);
        v = m ? long_done_data : v;
        return (a == {RF_AW{1'b0}}) ? rfData : v;
    endfunction

    function automatic logic laneHazard(input int j);
        logic [RF_AW-1:0] rs1;
        logic [RF_AW-1:0] rs2;
        logic [RF_AW-1:0] rd;
        logic [RF_AW-1:0] other;
        logic             use1;
        logic             use2;
        logic             older;
        logic             olderLong;
        logic             h;
        rs1       = dec_rs1_addr[j*RF_AW +: RF_AW];
        rs2       = dec_rs2_addr[j*RF_AW +: RF_AW];
        rd        = dec_rd_addr[j*RF_AW +: RF_AW];
        use1      = (rs1 != {RF_AW{1'b0}});
        use2      = (rs2 != {RF_AW{1'b0}});
        olderLong = 1'b0;
        h = (use1 & effBusy(rs1)) | (use2 & effBusy(rs2)) | (dec_rd_wen[j] & effBusy(rd));
        for (int i = 0; i < ISSUE_W; i++) begin
            other = ldRd_r[i*RF_AW +: RF_AW];
            h     = h | (ldValid_r[i] & ((use1 & (rs1 == other)) | (use2 & (rs2 == other))));
            older = (i < j);
            other = dec_rd_addr[i*RF_AW +: RF_AW];
            h     = h | (older & dec_valid[i] & dec_rd_wen[i] &
                         ((use1 & (rs1 == other)) | (use2 & (rs2 == other))));
            olderLong = olderLong | (older & dec_valid[i] & dec_is_long[i]);
        end
        h = h | (dec_is_long[j] & (~long_ready | olderLong));
        return h;
    endfunction

    // Operand forwarding for every lane and source.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            rs1_data[l*XLEN +: XLEN] = fwdOperand(dec_rs1_addr[l*RF_AW +: RF_AW], rf_rs1_data[l*XLEN +: XLEN]);
            rs2_data[l*XLEN +: XLEN] = fwdOperand(dec_rs2_addr[l*RF_AW +: RF_AW], rf_rs2_data[l*XLEN +: XLEN]);
        end
    end

    // Hazards and the in-order issue prefix; a held lane blocks every younger lane.
    always_comb begin
        hazard_s    = '0;
        issueMask_s = '0;
        laneGo_s    = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            hazard_s[j]    = laneHazard(j);
            issueMask_s[j] = dec_valid[j] & ~hazard_s[j] & ~flush &
                             ((j == 0) ? 1'b1 : issueMask_s[(j == 0) ? 0 : j - 1]);
            laneGo_s[j]    = issueMask_s[j] & issue_ready;
        end
        stallReq_s = ((|(dec_valid & ~issueMask_s)) & ~flush) | ((|dec_valid) & ~issue_ready);
    end

    // Scoreboard next state: completion clears, an issuing long op sets (set wins).
    always_comb begin
        busyNext_s               = busy_r;
        busyNext_s[long_done_rd] = busy_r[long_done_rd] & ~long_done;
        for (int i = 0; i < ISSUE_W; i++) begin
            busyNext_s[dec_rd_addr[i*RF_AW +: RF_AW]] = busyNext_s[dec_rd_addr[i*RF_AW +: RF_AW]] |
                (laneGo_s[i] & dec_is_long[i] & dec_rd_wen[i] &
                 (dec_rd_addr[i*RF_AW +: RF_AW] != {RF_AW{1'b0}}));
        end
    end

    // State registers: scoreboard, one-cycle load tracking, saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r     <= '0;
            ldValid_r  <= '0;
            ldRd_r     <= '0;
            stallCnt_r <= '0;
        end else begin
            busy_r <= busyNext_s;
            ldRd_r <= dec_rd_addr;
            for (int i = 0; i < ISSUE_W; i++) begin
                ldValid_r[i] <= laneGo_s[i] & dec_is_load[i] & dec_rd_wen[i] &
                                (dec_rd_addr[i*RF_AW +: RF_AW] != {RF_AW{1'b0}});
            end
            if (stallReq_s && (stallCnt_r != {CNT_W{1'b1}})) begin
                stallCnt_r <= stallCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stallCnt_r <= stallCnt_r;
            end
        end
    end

    assign issue_mask = issueMask_s;
    assign stall_req  = stallReq_s;
    assign stall_cnt  = stallCnt_r;

endmodule

// File: tb/tb_fwd_hazard_unit_n.sv
// Directed bench for fwd_hazard_unit_n (2 lanes, 4-bit stall counter so saturation is reachable).
module tb_fwd_hazard_unit_n;

    logic        clk = 1'b0;
    logic        rst_n, flush, issue_ready;
    logic [1:0]  dec_valid, dec_rd_wen, dec_is_load, dec_is_long;
    logic [9:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic [63:0] rf_rs1_data, rf_rs2_data;
    logic [9:0]  ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic [1:0]  ex_rd_wen, mem_rd_wen, mem_is_load, wb_rd_wen;
    logic [63:0] ex_alu_data, mem_alu_data, mem_ld_data, wb_data;
    logic        long_done, long_ready;
    logic [4:0]  long_done_rd;
    logic [31:0] long_done_data;
    logic [63:0] rs1_data, rs2_data;
    logic [1:0]  issue_mask;
    logic        stall_req;
    logic [3:0]  stall_cnt;

    int nChecks = 0;
    int nPass   = 0;

    fwd_hazard_unit_n #(.ISSUE_W(2), .XLEN(32), .RF_AW(5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .issue_ready(issue_ready),
        .dec_valid(dec_valid), .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rd_addr(dec_rd_addr), .dec_rd_wen(dec_rd_wen), .dec_is_load(dec_is_load),
        .dec_is_long(dec_is_long), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_alu_data(ex_alu_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_wen(mem_rd_wen), .mem_is_load(mem_is_load),
        .mem_alu_data(mem_alu_data), .mem_ld_data(mem_ld_data), .wb_rd_addr(wb_rd_addr),
        .wb_rd_wen(wb_rd_wen), .wb_data(wb_data), .long_done(long_done),
        .long_done_rd(long_done_rd), .long_done_data(long_done_data), .long_ready(long_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .issue_mask(issue_mask),
        .stall_req(stall_req), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearAll();
        flush = 1'b0; issue_ready = 1'b1; long_ready = 1'b1;
        dec_valid = '0; dec_rs1_addr = '0; dec_rs2_addr = '0; dec_rd_addr = '0;
        dec_rd_wen = '0; dec_is_load = '0; dec_is_long = '0;
        rf_rs1_data = {32'hAAAA_0001, 32'hAAAA_0000};
        rf_rs2_data = {32'hBBBB_0001, 32'hBBBB_0000};
        ex_rd_addr = '0; ex_rd_wen = '0; ex_alu_data = '0;
        mem_rd_addr = '0; mem_rd_wen = '0; mem_is_load = '0; mem_alu_data = '0; mem_ld_data = '0;
        wb_rd_addr = '0; wb_rd_wen = '0; wb_data = '0;
        long_done = 1'b0; long_done_rd = '0; long_done_data = '0;
    endtask

    task automatic lane(input int l, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wen, input logic ld, input logic lng);
        dec_valid[l] = v; dec_rs1_addr[l*5 +: 5] = rs1; dec_rs2_addr[l*5 +: 5] = rs2;
        dec_rd_addr[l*5 +: 5] = rd; dec_rd_wen[l] = wen; dec_is_load[l] = ld; dec_is_long[l] = lng;
    endtask

    initial begin
        clearAll();
        rst_n = 1'b0;
        tick(); tick();
        checkEq("rst_cnt", 64'(stall_cnt), 64'd0);
        checkEq("rst_mask", 64'(issue_mask), 64'd0);
        checkEq("rst_stall", 64'(stall_req), 64'd0);
        rst_n = 1'b1;

        // EX forwarding into lane 0
        lane(0, 1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        lane(1, 1'b1, 5'd6, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        dec_rs1_addr[9:5] = 5'd1;
        ex_rd_addr[4:0] = 5'd5; ex_rd_wen = 2'b01; ex_alu_data[31:0] = 32'h1234;
        #1;
        checkEq("ex_fwd", rs1_data[31:0], 64'h1234);
        checkEq("x0_rs2", rs2_data[31:0], 64'hBBBB_0000);
        checkEq("no_match_l1", rs1_data[63:32], 64'hAAAA_0001);
        checkEq("ex_mask", 64'(issue_mask), 64'b11);
        checkEq("ex_stall", 64'(stall_req), 64'd0);
        tick();

        // Priority chain on x7
        clearAll();
        lane(0, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        ex_rd_addr = {5'd7, 5'd7}; ex_rd_wen = 2'b11; ex_alu_data = {32'hB, 32'hA};
        mem_rd_addr = {5'd7, 5'd0}; mem_rd_wen = 2'b10; mem_alu_data = {32'hC, 32'h0};
        mem_ld_data = {32'hC1, 32'h0};
        #1; checkEq("ex_lane1_prio", rs1_data[31:0], 64'hB);
        ex_rd_wen = 2'b00;
        #1; checkEq("mem_alu", rs1_data[31:0], 64'hC);
        mem_is_load = 2'b10;
        #1; checkEq("mem_ld", rs1_data[31:0], 64'hC1);
        wb_rd_addr = {5'd0, 5'd7}; wb_rd_wen = 2'b01; wb_data = {32'h0, 32'hD};
        #1; checkEq("mem_over_wb", rs1_data[31:0], 64'hC1);
        mem_rd_wen = 2'b00;
        #1; checkEq("wb_fwd", rs1_data[31:0], 64'hD);
        long_done = 1'b1; long_done_rd = 5'd7; long_done_data = 32'hE;
        #1; checkEq("wb_over_long", rs1_data[31:0], 64'hD);
        wb_rd_wen = 2'b00;
        #1; checkEq("long_fwd", rs1_data[31:0], 64'hE);
        long_done = 1'b0;
        dec_rs1_addr[4:0] = 5'd0; ex_rd_addr[4:0] = 5'd0; ex_rd_wen = 2'b01; ex_alu_data[31:0] = 32'h99;
        #1; checkEq("x0_never_fwd", rs1_data[31:0], 64'hAAAA_0000);
        checkEq("prio_stall", 64'(stall_req), 64'd0);

        // Load-use: lw x3 then consumer in lane 1
        clearAll();
        lane(0, 1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        lane(1, 1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        #1; checkEq("lw_issue", 64'(issue_mask), 64'b11);
        tick();
        lane(0, 1'b1, 5'd2, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
        lane(1, 1'b1, 5'd3, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        #1; checkEq("lu_mask", 64'(issue_mask), 64'b01);
        checkEq("lu_stall", 64'(stall_req), 64'd1);
        tick();
        checkEq("lu_cnt", 64'(stall_cnt), 64'd1);
        mem_rd_addr[9:5] = 5'd3; mem_rd_wen = 2'b10; mem_is_load = 2'b10;
        mem_ld_data[63:32] = 32'hDEAD; mem_alu_data[63:32] = 32'h0BAD;
        #1; checkEq("lu_fwd", rs1_data[63:32], 64'hDEAD);
        checkEq("lu_mask2", 64'(issue_mask), 64'b11);
        tick();

        // Intra-bundle RAW, then invalid lane 0 blocks lane 1
        clearAll();
        lane(0, 1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        lane(1, 1'b1, 5'd9, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        #1; checkEq("raw_mask", 64'(issue_mask), 64'b01);
        tick();
        checkEq("raw_cnt", 64'(stall_cnt), 64'd2);
        clearAll();
        lane(0, 1'b1, 5'd9, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        #1; checkEq("raw_replay", 64'(issue_mask), 64'b01);
        checkEq("raw_replay_st", 64'(stall_req), 64'd0);
        tick();
        clearAll();
        lane(1, 1'b1, 5'd1, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
        #1; checkEq("gap_mask", 64'(issue_mask), 64'b00);
        checkEq("gap_stall", 64'(stall_req), 64'd1);
        tick();
        checkEq("gap_cnt", 64'(stall_cnt), 64'd3);

        // Long-latency scoreboard on x4
        clearAll();
        lane(0, 1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1);
        #1; checkEq("div_issue", 64'(issue_mask), 64'b01);
        tick();
        clearAll();
        lane(0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; checkEq("busy_mask", 64'(issue_mask), 64'b00);
        checkEq("busy_stall", 64'(stall_req), 64'd1);
        tick(); tick(); tick();
        checkEq("busy_cnt", 64'(stall_cnt), 64'd6);
        lane(0, 1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        #1; checkEq("waw_mask", 64'(issue_mask), 64'b00);
        lane(0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        long_done = 1'b1; long_done_rd = 5'd4; long_done_data = 32'h55;
        #1; checkEq("done_mask", 64'(issue_mask), 64'b01);
        checkEq("done_fwd", rs1_data[31:0], 64'h55);
        checkEq("done_stall", 64'(stall_req), 64'd0);
        tick();
        long_done = 1'b0;
        #1; checkEq("cleared_mask", 64'(issue_mask), 64'b01);
        checkEq("cleared_rf", rs1_data[31:0], 64'hAAAA_0000);
        checkEq("cleared_cnt", 64'(stall_cnt), 64'd6);

        // Two long ops in one bundle while IDEX is busy; no state update
        clearAll();
        issue_ready = 1'b0;
        lane(0, 1'b1, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
        lane(1, 1'b1, 5'd1, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1);
        #1; checkEq("two_long", 64'(issue_mask), 64'b01);
        checkEq("nready_stall", 64'(stall_req), 64'd1);
        tick();
        clearAll();
        long_ready = 1'b0;
        lane(0, 1'b1, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
        #1; checkEq("long_nready", 64'(issue_mask), 64'b00);
        clearAll();
        issue_ready = 1'b0;
        lane(0, 1'b1, 5'd1, 5'd0, 5'd20, 1'b1, 1'b1, 1'b0);
        #1; checkEq("ld_nready", 64'(issue_mask), 64'b01);
        tick();
        clearAll();
        lane(0, 1'b1, 5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        lane(1, 1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; checkEq("no_upd_mask", 64'(issue_mask), 64'b11);
        checkEq("no_upd_cnt", 64'(stall_cnt), 64'd8);
        tick();

        // Flush kills the bundle and still clears load tracking
        clearAll();
        lane(0, 1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        lane(0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        lane(1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1; checkEq("flush_mask", 64'(issue_mask), 64'b00);
        checkEq("flush_stall", 64'(stall_req), 64'd0);
        tick();
        flush = 1'b0;
        #1; checkEq("post_flush", 64'(issue_mask), 64'b11);
        checkEq("flush_cnt", 64'(stall_cnt), 64'd8);
        tick();

        // Saturation: 10 more stalled cycles from 8 clamp at 15
        clearAll();
        issue_ready = 1'b0;
        lane(0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++) tick();
        checkEq("sat_cnt", 64'(stall_cnt), 64'd15);

        // Reset in the middle of a scoreboard stall
        clearAll();
        lane(0, 1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1);
        tick();
        lane(0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; checkEq("pre_rst_stall", 64'(stall_req), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        checkEq("mid_rst_cnt", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;
        #1; checkEq("mid_rst_busy", 64'(issue_mask), 64'b01);
        checkEq("mid_rst_stall", 64'(stall_req), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
